multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Sequenced successor to the single-cycle opcode decoder: a Moore/Mealy FSM driving a shared-memory multi-cycle MIPS datapath.
- Covers R-type, lw, sw, beq, addi, andi and j, plus the custom jump-mem-indirect, store-and-increment and program-mem-copy instructions.
- Each access to the single memory port waits on a ready handshake.
- Sits between the instruction register and the datapath muxes, ALU control, register file and memory.

Parameters:
- OPCODE_W, 6, opcode field width; upper bits beyond 6 must be zero for a legal decode.
- ALU_OP_W, 2, width of alu_op; codes are zero-extended to this width.
- COUNT_W, 32, width of the performance counters; only used with the optional feature.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op_code  in  OPCODE_W  opcode from the instruction register; valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- register_destination  out  2  00 rt, 01 rd, 10 rs (base write-back)
- alu_op  out  ALU_OP_W  00 add, 01 sub, 10 funct, 11 and
- jump, branch, memory_read, memory_write, memory_to_register, alu_source  out  1 each  datapath controls
- reg_write, pc_control, memory_write_source, memory_read_source  out  1 each  datapath controls
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC update
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_op  out  1  one-cycle pulse on an undecodable opcode
- state  out  3  current FSM state, for debug

Behaviour:
- States, 3-bit encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, COPY_WRITE=4, WRITEBACK=5.
- Outputs default to 0 in every state. Only the controls listed for a state are asserted.
- Reset:
  - While reset=1, every output is 0 and state is FETCH.
  - Reset asserted mid-instruction abandons the instruction with no retire pulse. The next cycle after release is FETCH.
- FETCH:
  - memory_read=1.
  - When mem_ready=1: ir_write=1, pc_write=1 (PC+4 path), then go to DECODE. Otherwise hold.
- DECODE:
  - Latch op_code into op_q.
  - j: jump=1, pc_write=1, instr_done=1, then FETCH (2 cycles total with zero-wait memory).
  - Legal non-jump opcode: go to EXECUTE.
  - Illegal opcode: illegal_op=1, then FETCH with no retire.
- EXECUTE:
  - R-type: alu_op=10.
  - addi: alu_source=1, alu_op=00.
  - andi: alu_source=1, alu_op=11.
  - lw, sw, jmi (110000), sinc (110001), pmc (110010): alu_source=1, alu_op=00.
  - beq: branch=1, alu_op=01, instr_done=1, then FETCH.
  - Next state: R/addi/andi go to WRITEBACK; memory ops go to MEMORY.
- MEMORY holds, with controls stable, until mem_ready=1. Per opcode:
  - lw: memory_read=1, then WRITEBACK.
  - sw: memory_write=1, alu_source=1; instr_done on ready, then FETCH.
  - jmi: memory_read=1, pc_control=1; pc_write=1 and instr_done on ready, then FETCH.
  - sinc: memory_write=1, alu_source=1, then WRITEBACK.
  - pmc: memory_read=1, memory_read_source=1, pc_control=1, then COPY_WRITE.
- COPY_WRITE:
  - memory_write=1, memory_write_source=1, pc_control=1, alu_source=1.
  - Holds until mem_ready; on ready instr_done=1, then FETCH.
- WRITEBACK:
  - reg_write=1. instr_done=1.
  - register_destination: 01 for R-type, 10 for sinc, 00 otherwise.
  - memory_to_register=1 for lw only.
  - Next state: FETCH.
- mem_ready is ignored in DECODE, EXECUTE and WRITEBACK.
- Latency with zero-wait memory (mem_ready tied 1):
  - R/addi/andi: 4 cycles.
  - lw: 5. sw: 4. beq: 3. j: 2. jmi: 4. sinc: 5. pmc: 5.
- Each memory wait cycle adds one cycle to the instruction.
- op_code changing after DECODE has no effect; op_q governs.

Optional Feature:
- Macro: MCU_PERF_COUNTERS_EN.
- When defined, adds outputs cycle_count and instr_count, each COUNT_W bits, reset to 0.
  - cycle_count increments every non-reset cycle.
  - instr_count increments on instr_done.
  - Both wrap modulo 2^COUNT_W.
- When not defined, these ports and registers do not exist.

Decomposition:
- Package mcu_pkg holds:
  - opcode localparams: R, LW, SW, BEQ, ADDI, ANDI, J, JMI, SINC, PMC;
  - state encoding;
  - ALU_OP codes;
  - REGDST codes.
- Natural sub-module: mcu_output_decode, a combinational map from (state, op_q, mem_ready) to control outputs. The FSM register and next-state logic stay in the top.

Test Plan:
- Reset held 3 cycles mid-MEMORY of lw -> all outputs 0 during reset; state=0 the cycle after release; no instr_done.
- R-type, mem_ready=1 -> states 0,1,2,5; instr_done in cycle 4 with reg_write=1, register_destination=01, alu_op=10 in EXECUTE.
- lw with mem_ready low for 3 MEMORY cycles -> memory_read held 4 cycles; WRITEBACK asserts memory_to_register=1; 8 cycles total.
- pmc, mem_ready=1 -> MEMORY then COPY_WRITE; memory_read_source then memory_write_source asserted; pc_control=1 in both; instr_done in cycle 5.
- op_code=6'b111111 -> illegal_op pulse in DECODE; next state FETCH; instr_count unchanged.
- MCU_PERF_COUNTERS_EN with COUNT_W=4 -> run 17 j instructions; instr_count wraps to 1; cycle_count = 34 mod 16 = 2.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, FSM
// states, ALU and register-destination codes, and the control bundle.
package mcu_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JMI  = 6'b110000;
  localparam logic [5:0] OP_SINC = 6'b110001;
  localparam logic [5:0] OP_PMC  = 6'b110010;

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_DECODE     = 3'd1,
    S_EXECUTE    = 3'd2,
    S_MEMORY     = 3'd3,
    S_COPY_WRITE = 3'd4,
    S_WRITEBACK  = 3'd5
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RS = 2'b10;

  typedef struct packed {
    logic [1:0] register_destination;
    logic [1:0] alu_op;
    logic       jump;
    logic       branch;
    logic       memory_read;
    logic       memory_write;
    logic       memory_to_register;
    logic       alu_source;
    logic       reg_write;
    logic       pc_control;
    logic       memory_write_source;
    logic       memory_read_source;
    logic       ir_write;
    logic       pc_write;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI,
      OP_J, OP_JMI, OP_SINC, OP_PMC: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcu_output_decode.sv
// Combinational map from (state, opcode, mem_ready) to datapath controls.
module mcu_output_decode
  import mcu_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       op_legal_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  // Everything defaults low; each state raises only its own controls.
  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.memory_read = 1'b1;
        ctrl_o.ir_write    = mem_ready_i;
        ctrl_o.pc_write    = mem_ready_i;
      end
      S_DECODE: begin
        if (!op_legal_i) begin
          ctrl_o.illegal_op = 1'b1;
        end else if (op_i == OP_J) begin
          ctrl_o.jump       = 1'b1;
          ctrl_o.pc_write   = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
      end
      S_EXECUTE: begin
        case (op_i)
          OP_R:    ctrl_o.alu_op = ALU_FUNCT;
          OP_ANDI: begin
            ctrl_o.alu_source = 1'b1;
            ctrl_o.alu_op     = ALU_AND;
          end
          OP_BEQ: begin
            ctrl_o.branch     = 1'b1;
            ctrl_o.alu_op     = ALU_SUB;
            ctrl_o.instr_done = 1'b1;
          end
          default: begin
            ctrl_o.alu_source = 1'b1;
            ctrl_o.alu_op     = ALU_ADD;
          end
        endcase
      end
      S_MEMORY: begin
        case (op_i)
          OP_LW: ctrl_o.memory_read = 1'b1;
          OP_SW: begin
            ctrl_o.memory_write = 1'b1;
            ctrl_o.alu_source   = 1'b1;
            ctrl_o.instr_done   = mem_ready_i;
          end
          OP_JMI: begin
            ctrl_o.memory_read = 1'b1;
            ctrl_o.pc_control  = 1'b1;
            ctrl_o.pc_write    = mem_ready_i;
            ctrl_o.instr_done  = mem_ready_i;
          end
          OP_SINC: begin
            ctrl_o.memory_write = 1'b1;
            ctrl_o.alu_source   = 1'b1;
          end
          OP_PMC: begin
            ctrl_o.memory_read        = 1'b1;
            ctrl_o.memory_read_source = 1'b1;
            ctrl_o.pc_control         = 1'b1;
          end
          default: ;
        endcase
      end
      S_COPY_WRITE: begin
        ctrl_o.memory_write        = 1'b1;
        ctrl_o.memory_write_source = 1'b1;
        ctrl_o.pc_control          = 1'b1;
        ctrl_o.alu_source          = 1'b1;
        ctrl_o.instr_done          = mem_ready_i;
      end
      S_WRITEBACK: begin
        ctrl_o.reg_write          = 1'b1;
        ctrl_o.instr_done         = 1'b1;
        ctrl_o.memory_to_register = (op_i == OP_LW);
        if (op_i == OP_R)         ctrl_o.register_destination = REGDST_RD;
        else if (op_i == OP_SINC) ctrl_o.register_destination = REGDST_RS;
        else                      ctrl_o.register_destination = REGDST_RT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM for a shared single-port memory.
// Optional performance counters: define MCU_PERF_COUNTERS_EN.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned ALU_OP_W = 2,
  parameter int unsigned COUNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] op_code,
  input  logic                mem_ready,
  output logic [1:0]          register_destination,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                jump,
  output logic                branch,
  output logic                memory_read,
  output logic                memory_write,
  output logic                memory_to_register,
  output logic                alu_source,
  output logic                reg_write,
  output logic                pc_control,
  output logic                memory_write_source,
  output logic                memory_read_source,
  output logic                ir_write,
  output logic                pc_write,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [2:0]          state
`ifdef MCU_PERF_COUNTERS_EN
  ,
  output logic [COUNT_W-1:0]  cycle_count,
  output logic [COUNT_W-1:0]  instr_count
`endif
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] dec_op;
  logic       dec_legal;
  logic       hi_zero;
  ctrl_t      ctrl_raw, ctrl;

  // Bits above the 6-bit field must be clear for a legal decode.
  assign hi_zero   = ((op_code >> 6) == '0);
  // DECODE looks at the live opcode; later states use the latched copy only.
  assign dec_op    = (state_q == S_DECODE) ? op_code[5:0] : op_q;
  assign dec_legal = (state_q == S_DECODE) ? (hi_zero && op_is_legal(op_code[5:0])) : 1'b1;

  mcu_output_decode u_decode (
    .state_i     (state_q),
    .op_i        (dec_op),
    .op_legal_i  (dec_legal),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_raw)
  );

  // Next state and opcode latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = op_code[5:0];
        if (!dec_legal || op_code[5:0] == OP_J) state_d = S_FETCH;
        else                                    state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (op_q)
          OP_BEQ:                 state_d = S_FETCH;
          OP_R, OP_ADDI, OP_ANDI: state_d = S_WRITEBACK;
          default:                state_d = S_MEMORY;
        endcase
      end
      S_MEMORY: begin
        if (mem_ready) begin
          case (op_q)
            OP_LW, OP_SINC: state_d = S_WRITEBACK;
            OP_PMC:         state_d = S_COPY_WRITE;
            default:        state_d = S_FETCH;
          endcase
        end
      end
      S_COPY_WRITE: if (mem_ready) state_d = S_FETCH;
      S_WRITEBACK:  state_d = S_FETCH;
      default:      state_d = S_FETCH;
    endcase
  end

  // State and opcode registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Outputs are forced quiet for as long as reset is held, even before the
  // first clock edge has loaded state_q.
  assign ctrl  = reset ? '0 : ctrl_raw;
  assign state = reset ? 3'(S_FETCH) : 3'(state_q);

  assign register_destination = ctrl.register_destination;
  assign alu_op               = ALU_OP_W'(ctrl.alu_op);
  assign jump                 = ctrl.jump;
  assign branch               = ctrl.branch;
  assign memory_read          = ctrl.memory_read;
  assign memory_write         = ctrl.memory_write;
  assign memory_to_register   = ctrl.memory_to_register;
  assign alu_source           = ctrl.alu_source;
  assign reg_write            = ctrl.reg_write;
  assign pc_control           = ctrl.pc_control;
  assign memory_write_source  = ctrl.memory_write_source;
  assign memory_read_source   = ctrl.memory_read_source;
  assign ir_write             = ctrl.ir_write;
  assign pc_write             = ctrl.pc_write;
  assign instr_done           = ctrl.instr_done;
  assign illegal_op           = ctrl.illegal_op;

`ifdef MCU_PERF_COUNTERS_EN
  logic [COUNT_W-1:0] cycle_count_q, instr_count_q;

  // Free-running cycle and retire counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_q + 1'b1;
      if (ctrl.instr_done) instr_count_q <= instr_count_q + 1'b1;
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`endif

endmodule
